// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and (later) receiver:
// parity mode codes and the frame FSM state encoding.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    // Mode 2'b11 is an alias for no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: latches the divisor on load and pulses tick on the
// last clock of every bit period while enabled.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             w_terminal;

    assign w_terminal = (r_cnt == r_div);

    // Tick is deliberately not gated by load: the caller derives load from it.
    assign tick = en && w_terminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= DIV_W'(1);
            r_cnt <= '0;
        end else if (load) begin
            // Divisors 0 and 1 both give the two-clock minimum bit period.
            r_div <= (div < DIV_W'(2)) ? DIV_W'(1) : div;
            r_cnt <= '0;
        end else if (en) begin
            if (w_terminal) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Parametrised UART transmitter with a one-word holding register so that
// back-to-back frames leave the pin with no idle gap.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              stop_two,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rs232_tx,
    output logic              tx_done,
    output logic              busy,
    output logic              bit_tick
);

    localparam int IDX_W = $clog2(DATA_W);

    uart_state_e       r_state;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_stop_two;
    logic              r_stop_idx;
    logic              r_tx;

    logic              w_tick;
    logic              w_busy;
    logic              w_accept;
    logic              w_frame_end;
    logic              w_load;

    assign w_busy      = (r_state != S_IDLE);
    assign w_accept    = tx_valid && !r_hold_full;
    assign w_frame_end = (r_state == S_STOP) && w_tick && (r_stop_idx || !r_stop_two);
    // A held word starts a frame from IDLE or straight out of the final stop bit.
    assign w_load      = r_hold_full && ((r_state == S_IDLE) || w_frame_end);

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_busy),
        .load (w_load),
        .div  (baud_div),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop_two  <= 1'b0;
            r_stop_idx  <= 1'b0;
            r_tx        <= 1'b1;
        end else begin
            if (w_accept) begin
                r_hold <= tx_data;
            end

            if (w_load) begin
                // Move uses the old hold content; a same-edge accept keeps it full.
                r_hold_full <= w_accept;
                r_shift     <= r_hold;
                r_par_en    <= parity_enabled(parity_mode);
                r_par_bit   <= (^r_hold) ^ (parity_mode == PAR_ODD);
                r_stop_two  <= stop_two;
                r_stop_idx  <= 1'b0;
                r_bit_idx   <= '0;
                r_tx        <= 1'b0;
                r_state     <= S_START;
            end else begin
                if (w_accept) begin
                    r_hold_full <= 1'b1;
                end

                case (r_state)
                    S_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    S_START: begin
                        if (w_tick) begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_tick) begin
                            if (r_bit_idx == IDX_W'(DATA_W - 1)) begin
                                if (r_par_en) begin
                                    r_tx    <= r_par_bit;
                                    r_state <= S_PARITY;
                                end else begin
                                    r_tx       <= 1'b1;
                                    r_stop_idx <= 1'b0;
                                    r_state    <= S_STOP;
                                end
                            end else begin
                                r_tx      <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (w_tick) begin
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                            r_state    <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (w_frame_end) begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end else if (w_tick) begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rs232_tx = r_tx;
    assign tx_ready = !r_hold_full;
    assign busy     = w_busy;
    assign bit_tick = w_tick;
    assign tx_done  = w_frame_end;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: accepted words are queued, and a line monitor
// rebuilds each expected frame from the word and the config seen at its start.
module tb_uart_tx_ctrl;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DIV_W-1:0]  baud_div;
    logic [1:0]        parity_mode;
    logic              stop_two;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              rs232_tx;
    logic              tx_done;
    logic              busy;
    logic              bit_tick;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_q[$];

    logic [DIV_W-1:0] cfg_div_q;
    logic [1:0]       cfg_par_q;
    logic             cfg_stop_q;
    logic             rst_q;

    bit   in_frame   = 1'b0;
    bit   must_start = 1'b0;
    int   cyc;
    int   period;
    int   n_cycles;
    logic fbits [0:15];

    uart_tx_ctrl #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop_two    (stop_two),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rs232_tx    (rs232_tx),
        .tx_done     (tx_done),
        .busy        (busy),
        .bit_tick    (bit_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    // Accepted words and the configuration present at every active edge.
    always @(posedge clk) begin
        cfg_div_q  <= baud_div;
        cfg_par_q  <= parity_mode;
        cfg_stop_q <= stop_two;
        rst_q      <= rst;
        if (rst) begin
            exp_q.delete();
        end else if (tx_valid && tx_ready) begin
            exp_q.push_back(tx_data);
        end
    end

    // Line monitor: each frame is a list of bit levels, each bit held for one period.
    always @(negedge clk) begin
        logic [DATA_W-1:0] w;
        int nb;
        int ones;
        int d;
        if (rst_q) begin
            in_frame   = 1'b0;
            must_start = 1'b0;
            chk("reset_tx", rs232_tx, 1);
            chk("reset_ready", tx_ready, 1);
            chk("reset_busy", busy, 0);
            chk("reset_done", tx_done, 0);
            chk("reset_tick", bit_tick, 0);
        end else begin
            if (!in_frame && rs232_tx == 1'b0) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_start");
                end else begin
                    w    = exp_q.pop_front();
                    d    = int'(cfg_div_q);
                    period = ((d < 2) ? 1 : d) + 1;
                    nb   = 0;
                    ones = 0;
                    fbits[nb] = 1'b0;
                    nb++;
                    for (int i = 0; i < DATA_W; i++) begin
                        fbits[nb] = w[i];
                        ones += int'(w[i]);
                        nb++;
                    end
                    if (cfg_par_q == 2'b01) begin
                        fbits[nb] = (ones % 2 == 1);
                        nb++;
                    end else if (cfg_par_q == 2'b10) begin
                        fbits[nb] = (ones % 2 == 0);
                        nb++;
                    end
                    fbits[nb] = 1'b1;
                    nb++;
                    if (cfg_stop_q) begin
                        fbits[nb] = 1'b1;
                        nb++;
                    end
                    n_cycles = nb * period;
                    cyc      = 0;
                    in_frame = 1'b1;
                end
            end else if (!in_frame) begin
                if (must_start) note_fail("start_latency");
                chk("idle_tx", rs232_tx, 1);
                chk("idle_busy", busy, 0);
                chk("idle_done", tx_done, 0);
                chk("idle_tick", bit_tick, 0);
            end

            if (in_frame) begin
                chk("line_bit", rs232_tx, fbits[cyc / period]);
                chk("bit_tick", bit_tick, (cyc % period) == period - 1);
                chk("tx_done", tx_done, cyc == n_cycles - 1);
                chk("frame_busy", busy, 1);
                if (cyc == n_cycles - 1) in_frame = 1'b0;
                cyc++;
            end

            chk("tx_ready", tx_ready, exp_q.size() == 0);
            must_start = !in_frame && (exp_q.size() > 0);
        end
    end

    task automatic send_word(input logic [DATA_W-1:0] d);
        logic rdy;
        int   t;
        tx_data  = d;
        tx_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            rdy = tx_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            t++;
            if (t > 3000) begin
                note_fail("accept_timeout");
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || in_frame || busy) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 5000) note_fail("idle_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        note_fail("watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        rst         = 1'b1;
        tx_valid    = 1'b0;
        tx_data     = '0;
        baud_div    = 16'd4;
        parity_mode = 2'b00;
        stop_two    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 8N1 alternating pattern, then even/odd parity on the same word.
        send_word(8'h55);
        tx_valid = 1'b0;
        wait_idle();
        parity_mode = 2'b01;
        send_word(8'h07);
        tx_valid = 1'b0;
        wait_idle();
        parity_mode = 2'b10;
        send_word(8'h07);
        tx_valid = 1'b0;
        wait_idle();
        parity_mode = 2'b11;
        stop_two    = 1'b1;
        send_word(8'h7F);
        tx_valid = 1'b0;
        wait_idle();
        parity_mode = 2'b00;
        stop_two    = 1'b0;

        // Valid held across three words: frames must abut.
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        tx_valid = 1'b0;
        wait_idle();

        // Divisor change while the first frame is on the line.
        send_word(8'hA5);
        send_word(8'h3C);
        tx_valid = 1'b0;
        baud_div = 16'd9;
        wait_idle();
        baud_div = 16'd4;

        // Reset during data bit 3 with a second word held.
        send_word(8'hC3);
        send_word(8'h96);
        tx_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (150) @(posedge clk);
        #1;

        // Divisor 0 and 1 corner cases.
        baud_div = 16'd0;
        send_word(8'h81);
        tx_valid = 1'b0;
        wait_idle();
        baud_div = 16'd1;
        send_word(8'h18);
        tx_valid = 1'b0;
        wait_idle();

        // Random words, configs and gaps; config may change at any time.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                baud_div    = DIV_W'($urandom_range(0, 6));
                parity_mode = 2'($urandom_range(0, 3));
                stop_two    = 1'($urandom_range(0, 1));
            end
            send_word(DATA_W'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                tx_valid = 1'b0;
                repeat ($urandom_range(1, 60)) @(posedge clk);
                #1;
            end
        end
        tx_valid = 1'b0;
        wait_idle();

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Parametrised UART transmitter. Successor to the fixed 8N1 transmitter.
- Configurable data width, runtime baud divisor, parity (none/even/odd) and 1 or 2 stop bits.
- Valid/ready input handshake with a one-word holding register, so back-to-back frames go out with no idle gap.
- Sits between the packet/DPRAM readout logic and the RS232 pin.

Parameters:
- DATA_W, 8: data bits per frame; legal range 5..9.
- DIV_W, 16: width of the baud divisor input.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- baud_div  in  DIV_W  bit period minus one, in clk cycles; values 0 and 1 are treated as 1 (minimum 2 clocks per bit)
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
- stop_two  in  1  1 = two stop bits, 0 = one stop bit
- tx_data  in  DATA_W  word to send, LSB first
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty; transfer occurs when tx_valid && tx_ready at a clk edge
- rs232_tx  out  1  serial line, idle high, registered
- tx_done  out  1  one-cycle pulse at the end of each frame's final stop bit
- busy  out  1  FSM not in IDLE
- bit_tick  out  1  one-cycle pulse at each bit-period boundary (debug)

Behaviour:
- Reset: clock and reset are single-clock; reset is synchronous and active-high. Reset values: rs232_tx=1, tx_ready=1, tx_done=0, busy=0, bit_tick=0. Holding register cleared, divider counter cleared, FSM set to IDLE.
- Reset mid-frame aborts the frame. rs232_tx is 1 after the reset edge. Any held word is discarded.
- Holding register:
  - Accepting a word sets hold_full. tx_ready = !hold_full.
  - The word is moved to the shift register when the FSM enters START, which clears hold_full in the same edge.
  - Simultaneous accept and move: the move uses the old content and the new word is stored; hold_full stays 1.
  - tx_valid while tx_ready=0 is ignored; data is not sampled.
- Config sampling: baud_div, parity_mode and stop_two are captured on entry to START and held constant for the whole frame. Changes mid-frame affect only the next frame.
- Divider:
  - Counter runs only when busy. It resets to 0 on entry to START.
  - Counts 0..baud_div_latched; bit_tick pulses at the terminal count.
  - Every bit, including each stop bit, lasts exactly baud_div_latched+1 clocks.
- FSM states and transitions:
  - IDLE: rs232_tx=1. If hold_full, go to START at the next edge.
  - START: rs232_tx=0 for one bit period. Then DATA.
  - DATA: LSB-first shift of DATA_W bits, with a bit index counter 0..DATA_W-1. After bit DATA_W-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: one bit period. Even mode sends XOR of the data bits; odd mode sends its inverse. Then STOP.
  - STOP: rs232_tx=1 for 1 or 2 bit periods. At the final tick, tx_done pulses. Go to START if hold_full (zero idle cycles between frames), else IDLE.
- Latency: word accepted at edge k while IDLE → hold_full at k → START entered at edge k+1 → rs232_tx low from k+1.
- Frame length in clocks = (baud_div+1) × (1 + DATA_W + parity_en + 1 + stop_two).
- rs232_tx is driven from a register and is glitch-free.
- busy=1 from START entry until the edge that returns the FSM to IDLE.

Decomposition:
- Shared package uart_pkg:
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - FSM state enum / localparams S_IDLE, S_START, S_DATA, S_PARITY, S_STOP.
- One sub-module: uart_baud_gen.
  - Inputs: clk, rst, en, load, div.
  - Output: tick.
  - Implements the latched divisor and counter; shared later with the receiver.

Test Plan:
1. baud_div=4, 8N1, send 0x55 → rs232_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 5 clocks. tx_done pulses once 50 clocks after the start edge; busy then drops.
2. parity_mode=01, send 0x07 → parity bit 1. parity_mode=10, send 0x07 → parity bit 0. Frame length 55 clocks at baud_div=4.
3. stop_two=1, DATA_W=7, send 0x7F, no parity → stop-high period is 10 clocks; total 50 clocks.
4. tx_valid held high with 0x11, 0x22, 0x33 → second word accepted during the first frame, and tx_ready drops while held. Frames are contiguous with no extra idle cycle: the START edge immediately follows each tx_done cycle.
5. Change baud_div from 4 to 9 mid-frame → current frame keeps 5-clock bits; the next frame uses 10-clock bits.
6. Assert rst during DATA bit 3 with a word held → next cycle rs232_tx=1, tx_ready=1, busy=0. No tx_done, and the held word is never transmitted.
